// File: rtl/dwisehart_ring_grey_top.sv
// Free-running 8-bit Gray-code counter on the tile pad bus with a binary prescaler.
// Optional macro UPDOWN_EN lets io_in[7] select the count direction.
module dwisehart_ring_grey_top #(
   parameter int unsigned PRESCALE_W = 20,
   parameter int unsigned CNT_W      = 8
) (
   input  logic [7:0] io_in,
   output logic [7:0] io_out
);

   logic                  clk;
   logic                  rst_n;
   logic [4:0]            sel_k;
   logic                  down;
   logic [5:0]            k;
   logic [PRESCALE_W-1:0] mask;
   logic                  tick;
   logic [PRESCALE_W-1:0] pre_q;
   logic [PRESCALE_W-1:0] pre_d;
   logic [CNT_W-1:0]      cnt_q;
   logic [CNT_W-1:0]      cnt_d;
   logic [CNT_W-1:0]      gray_q;
   logic [CNT_W-1:0]      gray_d;

   assign clk   = io_in[0];
   assign rst_n = io_in[1];
   assign sel_k = io_in[6:2];

`ifdef UPDOWN_EN
   assign down = io_in[7];
`else
   logic unused_sel_dir;
   assign unused_sel_dir = io_in[7];
   assign down           = 1'b0;
`endif

   // Clamp the divide exponent to the prescaler width, then form a low-k-bit mask;
   // k == 0 gives an empty mask so tick is asserted every cycle.
   always_comb begin
      k    = {1'b0, sel_k};
      mask = '0;
      if (32'(sel_k) > PRESCALE_W) begin
         k = 6'(PRESCALE_W);
      end
      for (int i = 0; i < int'(PRESCALE_W); i++) begin
         mask[i] = (6'(i) < k);
      end
   end

   assign tick  = ((pre_q & mask) == mask);
   assign pre_d = pre_q + 1'b1;

   always_comb begin
      cnt_d = cnt_q;
      if (tick) begin
         cnt_d = down ? (cnt_q - 1'b1) : (cnt_q + 1'b1);
      end
      gray_d = cnt_d ^ {1'b0, cnt_d[CNT_W-1:1]};
   end

   // Gray value is registered alongside the counter so io_out has no combinational input path.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pre_q  <= '0;
         cnt_q  <= '0;
         gray_q <= '0;
      end else begin
         pre_q  <= pre_d;
         cnt_q  <= cnt_d;
         gray_q <= gray_d;
      end
   end

   assign io_out = gray_q;

endmodule

// File: tb/tb_dwisehart_ring_grey_top.sv
// Scoreboard bench for dwisehart_ring_grey_top; a second instance with a narrow
// prescaler exercises the exponent clamp within a short run.
module tb_dwisehart_ring_grey_top;

   logic       clk   = 1'b0;
   logic       rst_n = 1'b0;
   logic [5:0] sel   = 6'd0;
   logic [7:0] io_in;
   logic [7:0] io_in_c;
   logic [7:0] io_out;
   logic [7:0] io_out_c;

   int n_checks = 0;
   int n_fail   = 0;

   logic [7:0] exp_q[$];
   logic [7:0] exp_c_q[$];
   logic [7:0] prev;
   logic [7:0] seq[4];

   assign io_in   = {sel, rst_n, clk};
   assign io_in_c = {6'd31, rst_n, clk};

   dwisehart_ring_grey_top dut (
      .io_in  (io_in),
      .io_out (io_out)
   );

   dwisehart_ring_grey_top #(
      .PRESCALE_W (6)
   ) dut_clamp (
      .io_in  (io_in_c),
      .io_out (io_out_c)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [7:0] gray(input logic [7:0] c);
      return c ^ (c >> 1);
   endfunction

   // Push expectation, advance one edge, pop and compare against the DUT output.
   task automatic edge_check(input string tag, input logic [7:0] e);
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      check(tag, io_out, exp_q.pop_front());
   endtask

   task automatic do_reset(input logic [5:0] s);
      @(negedge clk);
      rst_n = 1'b0;
      sel   = s;
      #1;
      check("reset_async", io_out, 8'h00);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      #1ms;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // Reset held with clock running.
      for (int i = 0; i < 5; i++) edge_check("reset_hold", 8'h00);
      @(negedge clk);
      rst_n = 1'b1;

      // k = 0 sequence with Hamming-distance check.
      seq  = '{8'h01, 8'h03, 8'h02, 8'h06};
      prev = 8'h00;
      for (int i = 0; i < 4; i++) begin
         edge_check("k0_seq", seq[i]);
         check("k0_hamming", 32'($countones(io_out ^ prev)), 32'd1);
         prev = io_out;
      end

      // Asynchronous reset between edges while io_out == 06.
      #2;
      rst_n = 1'b0;
      #1;
      check("mid_reset", io_out, 8'h00);
      @(negedge clk);
      rst_n = 1'b1;
      edge_check("restart", 8'h01);

      // Divide by 4.
      do_reset(6'd2);
      for (int n = 1; n <= 8; n++) edge_check("div4", gray(8'(n >> 2)));

      // Full wrap at k = 0.
      do_reset(6'd0);
      prev = 8'h00;
      for (int n = 1; n <= 256; n++) begin
         edge_check("wrap", gray(8'(n)));
         if (io_out != prev) begin
            check("wrap_hamming", 32'($countones(io_out ^ prev)), 32'd1);
         end
         prev = io_out;
      end
      check("wrap_final", io_out, 8'h00);

      // Clamp: SEL = 31 saturates to the prescaler width on both instances.
      do_reset(6'd31);
      for (int n = 1; n <= 4000; n++) begin
         exp_q.push_back(8'h00);
         if (n <= 130) exp_c_q.push_back(gray(8'(n >> 6)));
         @(posedge clk);
         #1;
         check("clamp_main", io_out, exp_q.pop_front());
         if (n <= 130) check("clamp_w6", io_out_c, exp_c_q.pop_front());
      end

      // Direction select.
      do_reset(6'b100000);
`ifdef UPDOWN_EN
      seq = '{8'h80, 8'h81, 8'h83, 8'h82};
`else
      seq = '{8'h01, 8'h03, 8'h02, 8'h06};
`endif
      for (int i = 0; i < 4; i++) edge_check("dir_seq", seq[i]);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
